// File: rtl/axil_intf_arb.sv
// Two-port arbiter feeding one AXI-lite memory adaptor, with in-order response routing.
// Define AXIL_INTF_ARB_FIXED_PRI_EN for fixed port-0 priority; otherwise round-robin.
module axil_intf_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = 32,
  parameter int ORD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic                  s0_ren,
  input  logic [STRB_WIDTH-1:0] s0_wen,
  input  logic [TAG_WIDTH-1:0]  s0_req_tag,
  output logic                  s0_accept,
  output logic                  s0_val,
  output logic                  s0_error,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [TAG_WIDTH-1:0]  s0_resp_tag,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic                  s1_ren,
  input  logic [STRB_WIDTH-1:0] s1_wen,
  input  logic [TAG_WIDTH-1:0]  s1_req_tag,
  output logic                  s1_accept,
  output logic                  s1_val,
  output logic                  s1_error,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [TAG_WIDTH-1:0]  s1_resp_tag,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_ren,
  output logic [STRB_WIDTH-1:0] m_wen,
  output logic [TAG_WIDTH-1:0]  m_req_tag,
  input  logic                  m_accept,
  input  logic                  m_val,
  input  logic                  m_error,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [TAG_WIDTH-1:0]  m_resp_tag,
  output logic                  ord_err
);

  localparam int PW = $clog2(ORD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ORD_DEPTH);

  logic                 req0, req1, any_req, gnt;
  logic                 full, empty, xfer, pop, head;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ord_err_q, ord_err_d;
  logic [ORD_DEPTH-1:0] ord_mem_q, ord_mem_d;

  assign req0    = s0_ren | (|s0_wen);
  assign req1    = s1_ren | (|s1_wen);
  assign any_req = req0 | req1;

`ifdef AXIL_INTF_ARB_FIXED_PRI_EN
  assign gnt = ~req0;
`else
  logic rr_q, rr_d;

  // rr picks the winner only when both ports contend
  assign gnt = (req0 & req1) ? rr_q : req1;

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = ~gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  assign m_addr    = gnt ? s1_addr    : s0_addr;
  assign m_wdata   = gnt ? s1_wdata   : s0_wdata;
  assign m_req_tag = gnt ? s1_req_tag : s0_req_tag;
  assign m_ren     = any_req & ~full & (gnt ? s1_ren : s0_ren);
  assign m_wen     = (any_req & ~full) ? (gnt ? s1_wen : s0_wen) : '0;

  assign xfer      = rst_n & any_req & m_accept & ~full;
  assign s0_accept = xfer & ~gnt;
  assign s1_accept = xfer & gnt;

  // Responses come back in issue order, so the FIFO head names the destination
  assign pop  = m_val & ~empty;
  assign head = ord_mem_q[rd_ptr_q];

  assign s0_val      = pop & ~head;
  assign s1_val      = pop & head;
  assign s0_error    = s0_val & m_error;
  assign s1_error    = s1_val & m_error;
  assign s0_resp_tag = s0_val ? m_resp_tag : '0;
  assign s1_resp_tag = s1_val ? m_resp_tag : '0;
  assign s0_rdata    = m_rdata;
  assign s1_rdata    = m_rdata;
  assign ord_err     = ord_err_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ord_mem_d = ord_mem_q;
    ord_err_d = ord_err_q | (m_val & empty);
    if (xfer) begin
      ord_mem_d[wr_ptr_q] = gnt;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ord_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ord_err_q <= ord_err_d;
    end
  end

  // Entries are only read when the occupancy says they are valid, so no reset needed
  always_ff @(posedge clk) begin
    ord_mem_q <= ord_mem_d;
  end

endmodule

// File: tb/tb_axil_intf_arb.sv
// Bench for axil_intf_arb: directed scenarios then constrained-random traffic,
// checked against a queue-based model of arbitration and in-order response routing.
module tb_axil_intf_arb;
  localparam int DW = 32, AW = 32, SW = 4, TW = 32, OD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic [DW-1:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
  logic          s0_ren, s1_ren, m_ren;
  logic [SW-1:0] s0_wen, s1_wen, m_wen;
  logic [TW-1:0] s0_req_tag, s1_req_tag, m_req_tag, s0_resp_tag, s1_resp_tag, m_resp_tag;
  logic          s0_accept, s1_accept, s0_val, s1_val, s0_error, s1_error;
  logic          m_accept, m_val, m_error, ord_err;

  axil_intf_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TAG_WIDTH(TW),
                  .ORD_DEPTH(OD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_ren(s0_ren), .s0_wen(s0_wen),
    .s0_req_tag(s0_req_tag), .s0_accept(s0_accept), .s0_val(s0_val), .s0_error(s0_error),
    .s0_rdata(s0_rdata), .s0_resp_tag(s0_resp_tag),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_ren(s1_ren), .s1_wen(s1_wen),
    .s1_req_tag(s1_req_tag), .s1_accept(s1_accept), .s1_val(s1_val), .s1_error(s1_error),
    .s1_rdata(s1_rdata), .s1_resp_tag(s1_resp_tag),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ren(m_ren), .m_wen(m_wen), .m_req_tag(m_req_tag),
    .m_accept(m_accept), .m_val(m_val), .m_error(m_error), .m_rdata(m_rdata),
    .m_resp_tag(m_resp_tag), .ord_err(ord_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: next favoured port, queue of issued source ids, sticky error
  int  rr_m;
  int  src_q[$];
  bit  oerr_m;
  bit  macc0, macc1;

  // DUT values captured during the last step, for directed spot checks
  logic          o_acc0, o_acc1, o_mren, o_val0, o_val1, o_oerr;
  logic [TW-1:0] o_tag0, o_tag1;
  logic [AW-1:0] o_maddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s0_ren = 0; s0_wen = '0; s1_ren = 0; s1_wen = '0;
    m_accept = 0; m_val = 0; m_error = 0; m_resp_tag = '0;
  endtask

  task automatic do_reset();
    s0_ren = 1; s1_ren = 1; m_accept = 1;
    rst_n = 0;
    #1;
    chk("rst_s0_accept", s0_accept, 0);
    chk("rst_s1_accept", s1_accept, 0);
    chk("rst_ord_err", ord_err, 0);
    @(posedge clk); #1;
    rr_m = 0; src_q.delete(); oerr_m = 0;
    idle();
    rst_n = 1;
  endtask

  // One clock cycle: inputs already driven; check every output, then advance the model.
  task automatic step();
    bit r0, r1, any, full, xfer;
    int g, dest;
    m_rdata = $urandom;
    m_error = 1'($urandom_range(0, 1));
    #2;
    r0  = s0_ren || (s0_wen != 0);
    r1  = s1_ren || (s1_wen != 0);
    any = r0 || r1;
`ifdef AXIL_INTF_ARB_FIXED_PRI_EN
    g = r0 ? 0 : 1;
`else
    g = (r0 && r1) ? rr_m : (r1 ? 1 : 0);
`endif
    full = (src_q.size() == OD);
    xfer = any && m_accept && !full;
    chk("s0_accept", s0_accept, xfer && g == 0);
    chk("s1_accept", s1_accept, xfer && g == 1);
    if (any) begin
      chk("m_addr", m_addr, g ? s1_addr : s0_addr);
      chk("m_wdata", m_wdata, g ? s1_wdata : s0_wdata);
      chk("m_req_tag", m_req_tag, g ? s1_req_tag : s0_req_tag);
    end
    chk("m_ren", m_ren, (any && !full) ? (g ? s1_ren : s0_ren) : 1'b0);
    chk("m_wen", m_wen, (any && !full) ? (g ? s1_wen : s0_wen) : 4'h0);
    dest = (m_val && src_q.size() > 0) ? src_q[0] : -1;
    chk("s0_val", s0_val, dest == 0);
    chk("s1_val", s1_val, dest == 1);
    chk("s0_error", s0_error, (dest == 0) ? m_error : 1'b0);
    chk("s1_error", s1_error, (dest == 1) ? m_error : 1'b0);
    chk("s0_resp_tag", s0_resp_tag, (dest == 0) ? m_resp_tag : 32'h0);
    chk("s1_resp_tag", s1_resp_tag, (dest == 1) ? m_resp_tag : 32'h0);
    chk("s0_rdata", s0_rdata, m_rdata);
    chk("s1_rdata", s1_rdata, m_rdata);
    chk("ord_err", ord_err, oerr_m);
    o_acc0 = s0_accept; o_acc1 = s1_accept; o_mren = m_ren; o_maddr = m_addr;
    o_val0 = s0_val; o_val1 = s1_val; o_tag0 = s0_resp_tag; o_tag1 = s1_resp_tag;
    o_oerr = ord_err;
    if (m_val) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      else oerr_m = 1;
    end
    macc0 = xfer && g == 0;
    macc1 = xfer && g == 1;
    if (xfer) begin
      src_q.push_back(g);
      rr_m = 1 - g;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit pend0, pend1;
    idle();
    s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
    s0_req_tag = '0; s1_req_tag = '0; m_rdata = '0;
    rst_n = 1;
    @(posedge clk); #1;
    do_reset();

    // Both ports read continuously with the adaptor always ready
    s0_ren = 1; s1_ren = 1; m_accept = 1;
    s0_addr = 32'h100; s1_addr = 32'h200;
    step(); chk("arb_c1_s0", o_acc0, 1);
`ifdef AXIL_INTF_ARB_FIXED_PRI_EN
    step(); chk("arb_c2_s0", o_acc0, 1); chk("arb_c2_s1", o_acc1, 0);
    step(); chk("arb_c3_s0", o_acc0, 1); chk("arb_c3_s1", o_acc1, 0);
`else
    step(); chk("arb_c2_s1", o_acc1, 1); chk("arb_c2_s0", o_acc0, 0);
    step(); chk("arb_c3_s0", o_acc0, 1);
`endif
    do_reset();

    // Tagged read then write, responses routed back in order
    s0_ren = 1; s0_req_tag = 32'h11; m_accept = 1;
    step(); chk("ord_s0_issue", o_acc0, 1);
    s0_ren = 0; s1_wen = 4'hF; s1_req_tag = 32'h22; s1_wdata = 32'hCAFE_F00D;
    step(); chk("ord_s1_issue", o_acc1, 1);
    s1_wen = '0; m_accept = 0; m_val = 1; m_resp_tag = 32'h11;
    step(); chk("resp1_val0", o_val0, 1); chk("resp1_tag0", o_tag0, 32'h11);
    chk("resp1_val1", o_val1, 0);
    m_resp_tag = 32'h22;
    step(); chk("resp2_val1", o_val1, 1); chk("resp2_tag1", o_tag1, 32'h22);
    chk("resp2_val0", o_val0, 0);
    idle();

    // Fill the order FIFO, then free one slot
    s0_ren = 1; m_accept = 1;
    for (int i = 0; i < OD; i++) step();
    step(); chk("full_mren", o_mren, 0); chk("full_acc0", o_acc0, 0);
    m_val = 1;
    step(); chk("full_pop_acc0", o_acc0, 0);
    m_val = 0;
    step(); chk("after_pop_acc0", o_acc0, 1);
    s0_ren = 0; m_val = 1;
    for (int i = 0; i < OD; i++) step();
    idle();

    // Response with nothing outstanding
    do_reset();
    m_val = 1;
    step(); chk("orphan_val0", o_val0, 0); chk("orphan_val1", o_val1, 0);
    m_val = 0;
    step(); chk("orphan_err", o_oerr, 1);
    step(); chk("orphan_err_held", o_oerr, 1);
    do_reset();
    step(); chk("orphan_err_clr", o_oerr, 0);

    // Adaptor stalls with port 1 waiting
    s1_ren = 1; s1_addr = 32'hABCD_0040; m_accept = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_acc1", o_acc1, 0); chk("stall_addr", o_maddr, 32'hABCD_0040);
    end
    m_accept = 1;
    step(); chk("stall_release_acc1", o_acc1, 1);
    idle();

    // Randomized traffic; requesters hold until accepted
    do_reset();
    pend0 = 0; pend1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pend0) begin
        s0_ren = 0; s0_wen = '0;
        if ($urandom_range(0, 1)) begin
          pend0 = 1;
          if ($urandom_range(0, 1)) s0_ren = 1; else s0_wen = 4'($urandom_range(1, 15));
          s0_addr = $urandom; s0_wdata = $urandom; s0_req_tag = $urandom;
        end
      end
      if (!pend1) begin
        s1_ren = 0; s1_wen = '0;
        if ($urandom_range(0, 1)) begin
          pend1 = 1;
          if ($urandom_range(0, 1)) s1_ren = 1; else s1_wen = 4'($urandom_range(1, 15));
          s1_addr = $urandom; s1_wdata = $urandom; s1_req_tag = $urandom;
        end
      end
      m_accept   = ($urandom_range(0, 3) != 0);
      m_val      = (src_q.size() > 0) && ($urandom_range(0, 2) == 0);
      m_resp_tag = $urandom;
      step();
      if (macc0) pend0 = 0;
      if (macc1) pend1 = 0;
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_intf_arb.md
AXIL_INTF_ARB -- requirements
Module: axil_intf_arb

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data width; ADDR_WIDTH, default 32, address width; STRB_WIDTH, default DATA_WIDTH/8, write-strobe width; TAG_WIDTH, default 32, request/response tag width; ORD_DEPTH, default 4, maximum outstanding transfers (power of 2, at least 2).
REQ-002 SHALL have these ports: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have, for each requester port N in {0,1}: sN_addr  in  ADDR_WIDTH; sN_wdata  in  DATA_WIDTH; sN_ren  in  1; sN_wen  in  STRB_WIDTH; sN_req_tag  in  TAG_WIDTH.
REQ-005 SHALL have, for each N: sN_accept  out  1, meaning the request was taken this cycle; sN_val  out  1, response valid; sN_error  out  1; sN_rdata  out  DATA_WIDTH; sN_resp_tag  out  TAG_WIDTH.
REQ-006 SHALL have downstream outputs m_addr, m_wdata, m_ren, m_wen and m_req_tag, with the same widths as the sN_ inputs, driving the memory adaptor intf_* inputs.
REQ-007 SHALL have downstream inputs m_accept, m_val, m_error, m_rdata and m_resp_tag, driven by the adaptor intf_* outputs.
REQ-008 SHALL have: ord_err  out  1, a sticky flag meaning a response arrived with no outstanding entry.

Function
REQ-009 SHALL treat port N as requesting when sN_ren=1 or sN_wen is nonzero; a requester holds its request until sN_accept=1.
REQ-010 SHALL select the grant combinationally each cycle from the requesting ports using the round-robin pointer rr; on a tie, port rr wins.
REQ-011 SHALL drive the m_* request outputs from the granted port.
REQ-012 SHALL drive m_ren=0 and m_wen=0 when no port is requesting, or when the order FIFO is full.
REQ-013 SHALL define a transfer as: granted port requesting, and m_accept=1, and the order FIFO not full; on a transfer it SHALL assert sN_accept for the granted port only, in the same cycle.
REQ-014 SHALL hold sN_accept=0 for the non-granted port in every cycle.
REQ-015 SHALL, on each transfer, set rr to the other port, registered.
REQ-016 SHALL leave rr unchanged in any cycle without a transfer.
REQ-017 SHALL, on each transfer, push the granted source id (1 bit) into an order FIFO of depth ORD_DEPTH; responses return in issue order.
REQ-018 SHALL pop the order FIFO when m_val=1; the entry at the FIFO head selects the destination port.
REQ-019 SHALL, when m_val=1 and the FIFO is not empty, set sHEAD_val=1, and copy m_error, m_rdata and m_resp_tag to sHEAD_error, sHEAD_rdata and sHEAD_resp_tag in the same cycle (combinational, zero latency).
REQ-020 SHALL, on that response, drive the other port's val, error and resp_tag to 0; sN_rdata SHALL equal m_rdata at all times.
REQ-021 SHALL, when push and pop occur in the same cycle, keep the occupancy unchanged; a full FIFO with a simultaneous pop still blocks the push in that cycle (full is registered).
REQ-022 SHALL, when m_val=1 with the FIFO empty, drop the response, assert no sN_val, and set ord_err=1 until reset.
REQ-023 SHALL wrap the FIFO read and write pointers modulo ORD_DEPTH, and derive full and empty from a separate occupancy counter of $clog2(ORD_DEPTH)+1 bits.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear rr to 0, clear the FIFO pointers, occupancy and ord_err, and hold sN_accept=0.
REQ-025 SHALL drop every outstanding entry when rst_n asserts mid-operation; any response arriving afterwards sets ord_err.
REQ-026 SHALL leave the request outputs as combinational functions of the inputs.
REQ-027 SHALL drive all sN_val and sN_accept low in the first cycle after reset release unless the condition of REQ-013 or REQ-019 holds.

Configuration
REQ-028 SHALL, when AXIL_INTF_ARB_FIXED_PRI_EN is defined, always grant port 0 over port 1; rr SHALL NOT be implemented; all other behaviour SHALL be unchanged.
REQ-029 SHALL implement the round-robin behaviour of REQ-010 and REQ-015 when AXIL_INTF_ARB_FIXED_PRI_EN is not defined.

Verification
REQ-030 SHALL cover: after reset, both ports read with m_accept=1 every cycle -> s0 accepted in cycle 1, s1 in cycle 2, s0 again in cycle 3 (default build).
REQ-031 SHALL cover: the same stimulus with AXIL_INTF_ARB_FIXED_PRI_EN defined -> s0 accepted every cycle; s1 never accepted while s0 requests.
REQ-032 SHALL cover: s0 read with tag 0x11, then s1 write with tag 0x22, then m_val pulses twice -> s0_val with resp_tag 0x11, then s1_val with resp_tag 0x22; no cross-port val.
REQ-033 SHALL cover: issue 4 requests with m_val=0 (ORD_DEPTH=4) -> fifth request sees m_ren=0 and sN_accept=0; after one m_val, the fifth is accepted in the next cycle.
REQ-034 SHALL cover: m_val=1 with no outstanding request -> no sN_val, ord_err=1 and held; rst_n pulse -> ord_err=0.
REQ-035 SHALL cover: m_accept=0 for 3 cycles with s1 requesting -> s1_accept=0 and s1 request held stable on m_*; accepted in the cycle m_accept rises.
